// File: rtl/pifo_pkg.sv
// Shared types and helpers for the PIFO flow scheduler enqueue path.
package pifo_pkg;

  typedef logic [31:0] rank_t;

  localparam rank_t RANK_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] value;
    rank_t       rank;
  } pkt_t;

  // Unsigned add that clamps at RANK_MAX instead of wrapping.
  function automatic rank_t sat_add(rank_t a, rank_t b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? RANK_MAX : sum[31:0];
  endfunction

endpackage

// File: rtl/stfq_rank_calc.sv
// Start-Time Fair Queueing tag computation: start = max(vtime, base), finish = start + len.
module stfq_rank_calc
  import pifo_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic [31:0]      vtime,
  input  logic [31:0]      base,
  input  logic [LEN_W-1:0] len,
  output logic [31:0]      start,
  output logic [31:0]      finish
);

  assign start  = (base > vtime) ? base : vtime;
  assign finish = sat_add(start, rank_t'(len));

endmodule

// File: rtl/stfq_enqueue_driver.sv
// Two-lane STFQ enqueue initiator: ranks packets, compacts them onto push_1/push_2
// and keeps a private credit count of scheduler occupancy.
module stfq_enqueue_driver
  import pifo_pkg::*;
#(
  parameter int NUM_FLOWS = 8,
  parameter int PIFO_SIZE = 10,
  parameter int LEN_W     = 16,
  localparam int FLOW_W   = $clog2(NUM_FLOWS),
  localparam int OCC_W    = $clog2(PIFO_SIZE + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_0,
  input  logic [FLOW_W-1:0] in_flow_0,
  input  logic [LEN_W-1:0]  in_len_0,
  input  logic [31:0]       in_value_0,
  output logic              in_ready_0,
  input  logic              in_valid_1,
  input  logic [FLOW_W-1:0] in_flow_1,
  input  logic [LEN_W-1:0]  in_len_1,
  input  logic [31:0]       in_value_1,
  output logic              in_ready_1,
  output logic              push_1,
  output logic              push_2,
  output logic [31:0]       push_rank_1,
  output logic [31:0]       push_rank_2,
  output logic [31:0]       push_value_1,
  output logic [31:0]       push_value_2,
  input  logic              pop,
  input  logic              deq_valid,
  input  logic [31:0]       deq_rank,
  output logic [OCC_W-1:0]  occupancy
);

  localparam logic [OCC_W-1:0] CAP = OCC_W'(PIFO_SIZE);

  rank_t            last_finish [NUM_FLOWS];
  rank_t            vtime;
  logic [OCC_W-1:0] free;
  logic             acc_0, acc_1;
  rank_t            base_1;
  rank_t            start_0, finish_0, start_1, finish_1;
  logic             pop_eff;
  logic             nxt_p1, nxt_p2;
  pkt_t             nxt_1, nxt_2;

  // Credits: a pop seen this cycle only frees space from the next cycle on.
  assign free  = CAP - occupancy;
  assign acc_0 = !rst && in_valid_0 && (free != '0);
  assign acc_1 = !rst && in_valid_1 &&
                 (in_valid_0 ? (free >= OCC_W'(2)) : (free != '0));

  assign in_ready_0 = acc_0;
  assign in_ready_1 = acc_1;

  stfq_rank_calc #(.LEN_W(LEN_W)) u_calc_0 (
    .vtime  (vtime),
    .base   (last_finish[in_flow_0]),
    .len    (in_len_0),
    .start  (start_0),
    .finish (finish_0)
  );

  // Same-flow pair: lane 1 starts where the accepted lane-0 packet finishes.
  assign base_1 = (acc_0 && (in_flow_1 == in_flow_0)) ? finish_0
                                                      : last_finish[in_flow_1];

  stfq_rank_calc #(.LEN_W(LEN_W)) u_calc_1 (
    .vtime  (vtime),
    .base   (base_1),
    .len    (in_len_1),
    .start  (start_1),
    .finish (finish_1)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nxt_p1 = 1'b0;
    nxt_p2 = 1'b0;
    nxt_1  = '0;
    nxt_2  = '0;
    if (acc_0) begin
      nxt_p1 = 1'b1;
      nxt_1  = '{value: in_value_0, rank: start_0};
      if (acc_1) begin
        nxt_p2 = 1'b1;
        nxt_2  = '{value: in_value_1, rank: start_1};
      end
    end else if (acc_1) begin
      nxt_p1 = 1'b1;
      nxt_1  = '{value: in_value_1, rank: start_1};
    end
  end

  assign pop_eff = pop && (occupancy != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_1       <= 1'b0;
      push_2       <= 1'b0;
      push_rank_1  <= '0;
      push_rank_2  <= '0;
      push_value_1 <= '0;
      push_value_2 <= '0;
      occupancy    <= '0;
      vtime        <= '0;
    end else begin
      push_1       <= nxt_p1;
      push_2       <= nxt_p2;
      push_rank_1  <= nxt_1.rank;
      push_rank_2  <= nxt_2.rank;
      push_value_1 <= nxt_1.value;
      push_value_2 <= nxt_2.value;
      occupancy    <= occupancy + OCC_W'(acc_0) + OCC_W'(acc_1) - OCC_W'(pop_eff);
      if (deq_valid && (deq_rank > vtime)) vtime <= deq_rank;
    end
  end

  // NOTE: the flow table is small and flop-based, so it is cleared on reset;
  // an idle flow must read a finish time of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_FLOWS; i++) last_finish[i] <= '0;
    end else begin
      if (acc_0) last_finish[in_flow_0] <= finish_0;
      // Later assignment wins, so a same-flow lane 1 overrides lane 0.
      if (acc_1) last_finish[in_flow_1] <= finish_1;
    end
  end

endmodule

// File: tb/tb_stfq_enqueue_driver.sv
// Table-driven bench for stfq_enqueue_driver with a scoreboard of expected push beats.
module tb_stfq_enqueue_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_0, in_valid_1;
  logic [2:0]  in_flow_0, in_flow_1;
  logic [15:0] in_len_0, in_len_1;
  logic [31:0] in_value_0, in_value_1;
  logic        in_ready_0, in_ready_1;
  logic        push_1, push_2;
  logic [31:0] push_rank_1, push_rank_2, push_value_1, push_value_2;
  logic        pop, deq_valid;
  logic [31:0] deq_rank;
  logic [3:0]  occupancy;

  always #5 clk = ~clk;

  stfq_enqueue_driver dut (
    .clk(clk), .rst(rst),
    .in_valid_0(in_valid_0), .in_flow_0(in_flow_0), .in_len_0(in_len_0),
    .in_value_0(in_value_0), .in_ready_0(in_ready_0),
    .in_valid_1(in_valid_1), .in_flow_1(in_flow_1), .in_len_1(in_len_1),
    .in_value_1(in_value_1), .in_ready_1(in_ready_1),
    .push_1(push_1), .push_2(push_2),
    .push_rank_1(push_rank_1), .push_rank_2(push_rank_2),
    .push_value_1(push_value_1), .push_value_2(push_value_2),
    .pop(pop), .deq_valid(deq_valid), .deq_rank(deq_rank),
    .occupancy(occupancy)
  );

  typedef struct {
    logic        v0; logic [2:0] f0; logic [15:0] l0; logic [31:0] val0;
    logic        v1; logic [2:0] f1; logic [15:0] l1; logic [31:0] val1;
    logic        pop; logic deqv; logic [31:0] deqr;
    logic        r0, r1, p1, p2;
    logic [31:0] rk1, rk2, vl1, vl2;
    logic [3:0]  occ;
  } vec_t;

  typedef struct {
    logic        p1, p2;
    logic [31:0] rk1, rk2, vl1, vl2;
    logic [3:0]  occ;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic v0, input logic [2:0] f0, input logic [15:0] l0, input logic [31:0] val0,
    input logic v1, input logic [2:0] f1, input logic [15:0] l1, input logic [31:0] val1,
    input logic pp, input logic dv, input logic [31:0] dr,
    input logic r0, input logic r1, input logic p1, input logic p2,
    input logic [31:0] rk1, input logic [31:0] rk2,
    input logic [31:0] vl1, input logic [31:0] vl2, input logic [3:0] occ);
    vec_t v;
    v.v0 = v0; v.f0 = f0; v.l0 = l0; v.val0 = val0;
    v.v1 = v1; v.f1 = f1; v.l1 = l1; v.val1 = val1;
    v.pop = pp; v.deqv = dv; v.deqr = dr;
    v.r0 = r0; v.r1 = r1; v.p1 = p1; v.p2 = p2;
    v.rk1 = rk1; v.rk2 = rk2; v.vl1 = vl1; v.vl2 = vl2; v.occ = occ;
    return v;
  endfunction

  task automatic idle_inputs();
    in_valid_0 = 0; in_flow_0 = 0; in_len_0 = 0; in_value_0 = 0;
    in_valid_1 = 0; in_flow_1 = 0; in_len_1 = 0; in_value_1 = 0;
    pop = 0; deq_valid = 0; deq_rank = 0;
  endtask

  // Drive one cycle, check readiness, queue the expected beat, then check it after the edge.
  task automatic apply(input string tag, input vec_t v);
    exp_t e, got;
    @(negedge clk);
    in_valid_0 = v.v0; in_flow_0 = v.f0; in_len_0 = v.l0; in_value_0 = v.val0;
    in_valid_1 = v.v1; in_flow_1 = v.f1; in_len_1 = v.l1; in_value_1 = v.val1;
    pop = v.pop; deq_valid = v.deqv; deq_rank = v.deqr;
    #1;
    check({tag, ".ready"}, 64'({in_ready_0, in_ready_1}), 64'({v.r0, v.r1}));
    e.p1 = v.p1; e.p2 = v.p2; e.rk1 = v.rk1; e.rk2 = v.rk2;
    e.vl1 = v.vl1; e.vl2 = v.vl2; e.occ = v.occ;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      got = sb.pop_front();
      check({tag, ".strobes"}, 64'({push_1, push_2}), 64'({got.p1, got.p2}));
      if (got.p1) check({tag, ".beat1"}, {push_rank_1, push_value_1}, {got.rk1, got.vl1});
      if (got.p2) check({tag, ".beat2"}, {push_rank_2, push_value_2}, {got.rk2, got.vl2});
      check({tag, ".occ"}, 64'(occupancy), 64'(got.occ));
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    in_valid_0 = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset.ready", 64'({in_ready_0, in_ready_1}), 64'd0);
    check("reset.outs", 64'({push_1, push_2, occupancy}), 64'd0);
    check("reset.data", {push_rank_1 | push_rank_2, push_value_1 | push_value_2}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();

    //           v0 f0 len     val      v1 f1 len   val      pop dv rank  r0 r1 p1 p2 rk1 rk2 vl1     vl2    occ
    tbl[0]  = mk(1, 2, 100,  32'h07,  0, 0, 0,  32'h00,  0, 0, 0,    1, 0, 1, 0, 0,  0,  32'h07, 0,      1);
    tbl[1]  = mk(1, 3, 10,   32'h11,  1, 3, 20, 32'h12,  0, 0, 0,    1, 1, 1, 1, 0,  10, 32'h11, 32'h12, 3);
    tbl[2]  = mk(0, 1, 77,   32'hEE,  1, 1, 5,  32'h21,  0, 0, 0,    0, 1, 1, 0, 0,  0,  32'h21, 0,      4);
    tbl[3]  = mk(1, 2, 50,   32'h31,  1, 3, 1,  32'h32,  0, 0, 0,    1, 1, 1, 1, 100,30, 32'h31, 32'h32, 6);
    tbl[4]  = mk(1, 0, 1,    32'h41,  1, 6, 1,  32'h42,  0, 0, 0,    1, 1, 1, 1, 0,  0,  32'h41, 32'h42, 8);
    tbl[5]  = mk(1, 7, 2,    32'h51,  0, 0, 0,  32'h00,  0, 0, 0,    1, 0, 1, 0, 0,  0,  32'h51, 0,      9);
    tbl[6]  = mk(1, 0, 3,    32'h61,  1, 6, 3,  32'h62,  0, 0, 0,    1, 0, 1, 0, 1,  0,  32'h61, 0,      10);
    tbl[7]  = mk(1, 0, 3,    32'h71,  1, 6, 3,  32'h72,  0, 0, 0,    0, 0, 0, 0, 0,  0,  0,      0,      10);
    tbl[8]  = mk(1, 0, 3,    32'h81,  1, 6, 3,  32'h82,  1, 0, 0,    0, 0, 0, 0, 0,  0,  0,      0,      9);
    tbl[9]  = mk(1, 0, 3,    32'h91,  1, 6, 3,  32'h92,  0, 0, 0,    1, 0, 1, 0, 4,  0,  32'h91, 0,      10);
    tbl[10] = mk(1, 0, 3,    32'hA1,  0, 0, 0,  32'h00,  0, 0, 0,    0, 0, 0, 0, 0,  0,  0,      0,      10);
    tbl[11] = mk(0, 0, 0,    32'h00,  1, 4, 3,  32'hB2,  0, 0, 0,    0, 0, 0, 0, 0,  0,  0,      0,      10);
    for (int i = 0; i < 12; i++) apply($sformatf("vec%0d", i), tbl[i]);

    // Drain the credits, with one extra pop to probe underflow.
    for (int i = 0; i < 11; i++)
      apply($sformatf("drain%0d", i),
            mk(0,0,0,0, 0,0,0,0, 1,0,0, 0,0,0,0, 0,0,0,0, 4'((i < 10) ? 9 - i : 0)));

    // Virtual time: same-cycle deq does not affect the current rank; later ranks use it.
    apply("vt_same", mk(1,2,10,32'hC1, 0,0,0,0, 0,1,500, 1,0,1,0, 150,0,32'hC1,0, 1));
    apply("vt_idle", mk(1,4,10,32'hC2, 0,0,0,0, 0,0,0,   1,0,1,0, 500,0,32'hC2,0, 2));
    apply("vt_low",  mk(0,0,0,0,       0,0,0,0, 0,1,200, 0,0,0,0, 0,0,0,0,          2));
    apply("vt_mono", mk(0,0,0,0,       1,5,1,32'hC3, 0,0,0, 0,1,1,0, 500,0,32'hC3,0, 3));

    // Saturating finish time, observed through the next rank on the same flow.
    apply("sat_vt",  mk(0,0,0,0, 0,0,0,0, 0,1,32'hFFFF_FF00, 0,0,0,0, 0,0,0,0, 3));
    apply("sat_a",   mk(1,5,16'h0200,32'hD1, 0,0,0,0, 0,0,0, 1,0,1,0, 32'hFFFF_FF00,0,32'hD1,0, 4));
    apply("sat_b",   mk(1,5,0,32'hD2, 1,5,0,32'hD3, 0,0,0, 1,1,1,1, 32'hFFFF_FFFF,32'hFFFF_FFFF,32'hD2,32'hD3, 6));

    // Reset asserted during an accepting cycle drops the in-flight push.
    @(negedge clk);
    in_valid_0 = 1; in_flow_0 = 1; in_len_0 = 9; in_value_0 = 32'hE1;
    #1;
    check("rst_mid.pre_ready", 64'(in_ready_0), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid.ready", 64'(in_ready_0), 64'd0);
    check("rst_mid.occ_async", 64'(occupancy), 64'd0);
    @(posedge clk);
    #1;
    check("rst_mid.push", 64'({push_1, push_2}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    apply("post_rst", mk(1,5,1,32'hF1, 0,0,0,0, 0,0,0, 1,0,1,0, 0,0,32'hF1,0, 1));
    apply("post_idle", mk(0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 1));

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stfq_enqueue_driver.md
Name: stfq_enqueue_driver

Overview:
- Enqueue-side initiator for the two-push PIFO flow scheduler.
- Accepts packets on two ingress lanes and computes a Start-Time Fair Queueing rank for each: rank = max(virtual time, flow's last finish).
- Issues registered push_1/push_2 beats, compacting lanes so push_2 is never asserted without push_1.
- Tracks scheduler occupancy with its own credit counter, so it never overfills the scheduler despite the one-cycle push latency.

Parameters:
- NUM_FLOWS, 8, number of flows tracked in the per-flow finish-time table (power of two).
- PIFO_SIZE, 10, capacity of the downstream scheduler (>1).
- LEN_W, 16, packet length width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid_0  in  1  lane 0 packet valid
- in_flow_0  in  $clog2(NUM_FLOWS)  lane 0 flow id
- in_len_0  in  LEN_W  lane 0 length (weight-scaled)
- in_value_0  in  32  lane 0 payload/descriptor
- in_ready_0  out  1  lane 0 accepted this cycle
- in_valid_1 / in_flow_1 / in_len_1 / in_value_1 / in_ready_1: lane 1, same widths and meanings
- push_1, push_2  out  1  scheduler push strobes
- push_rank_1, push_rank_2  out  32  ranks
- push_value_1, push_value_2  out  32  values
- pop  in  1  tap of the scheduler pop strobe (decrements credits)
- deq_valid  in  1  downstream reports a dequeued packet's rank
- deq_rank  in  32  rank of that dequeued packet
- occupancy  out  $clog2(PIFO_SIZE+1)  credit counter value

Interface: one clock; reset is asynchronous and active-high (clk, rst).

Behaviour:
- Reset (async, rst=1):
  - push_1, push_2, push_rank_*, push_value_* = 0.
  - occupancy = 0, vtime = 0, all last_finish[] = 0.
  - in_ready_* = 0 while rst is asserted.
- Acceptance (combinational), with free = PIFO_SIZE - occupancy:
  - Both lanes valid: free>=2 accepts both; free==1 accepts lane 0 only; free==0 accepts none.
  - Single lane valid: accepted when free>=1.
  - in_ready_k = accepted_k. There is no ready-before-valid promise.
  - The pop seen in the same cycle is not credited until the next cycle (conservative).
- Rank computation for an accepted packet:
  - Lane 0: start0 = max(vtime, last_finish[flow0]).
  - Lane 1:
    - flow1==flow0 and lane 0 also accepted: base = finish0.
    - Otherwise: base = last_finish[flow1].
    - start1 = max(vtime, base).
  - finish = start + len, saturating at 32'hFFFF_FFFF.
  - rank = start.
- Issue (registered, 1-cycle latency). At the edge after acceptance:
  - Both accepted: push_1 = lane 0, push_2 = lane 1.
  - Only lane 1 accepted: it is placed on push_1 and push_2 = 0.
  - push_2 is never 1 while push_1 is 0.
  - Strobes are single-cycle; they drop to 0 the next cycle unless new packets are accepted.
- Table update, at the same edge:
  - last_finish[flow] <= finish.
  - Same flow on both lanes: lane 1's finish wins.
  - A packet accepted in the next cycle reads the updated value.
- Credits:
  - occupancy <= occupancy + n_accepted - pop.
  - pop with occupancy==0 is ignored; no underflow.
  - n_accepted is never more than free, so occupancy never exceeds PIFO_SIZE.
- Virtual time:
  - On deq_valid, vtime <= max(vtime, deq_rank); vtime is monotonic.
  - A deq_valid in the same cycle as an acceptance affects only ranks computed in later cycles.
- Reset mid-operation: all state clears immediately; an in-flight registered push is dropped.

Decomposition:
- Package pifo_pkg holds:
  - rank_t (logic [31:0]);
  - RANK_MAX;
  - typedef pkt_t {value, rank};
  - the saturating-add function sat_add.
- One sub-module, stfq_rank_calc: purely combinational; vtime, base and len in; start and finish out. Instantiated twice.
- The flow table, credits, vtime and output registers live in the top.

Test Plan:
- Reset then single lane 0 packet {flow 2, len 100, value 7} → next cycle push_1=1, rank 0, value 7, push_2=0; last_finish[2]=100; occupancy=1.
- Same cycle, both lanes flow 3 with len 10 and len 20, vtime 0 → push_1 rank 0, push_2 rank 10; last_finish[3]=30; occupancy+=2.
- Lane 1 alone valid (flow 1, len 5) → appears on push_1, push_2=0.
- Fill to occupancy 9, then both lanes valid → only lane 0 ready, occupancy 10. Next cycle both valid again → neither ready. Assert pop one cycle → the following cycle lane 0 is ready.
- deq_valid with deq_rank 500, then packet on idle flow 4 (last_finish 0) → rank 500. Then deq_rank 200 → vtime stays 500.
- last_finish[5]=32'hFFFF_FF00, len 0x200 → finish saturates to 32'hFFFF_FFFF.
- Assert rst during an accepted cycle → push_1 stays 0 and occupancy reads 0 asynchronously.
